// File: rtl/reg_file_sb.sv
// RV32 integer register file with two combinational read ports, one write port
// and a pending-write scoreboard that decode uses to stall on RAW hazards.
module reg_file_sb #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit WR_BYPASS = 1'b1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            regf_write_i,
  input  logic [AW-1:0]   regf_waddr_i,
  input  logic [XLEN-1:0] regf_wdata_i,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            sb_set_i,
  input  logic [AW-1:0]   sb_set_rd_i,
  input  logic            sb_flush_i,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  output logic            stall_o
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_valid;

  assign wr_valid = regf_write_i && (regf_waddr_i != '0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_valid) begin
      regs[regf_waddr_i] <= regf_wdata_i;
    end
  end

  // A set is issued by a younger producer, so it is applied after the clear
  // and wins when both target the same register; flush overrides everything.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      busy <= '0;
    end else if (sb_flush_i) begin
      busy <= '0;
    end else begin
      if (wr_valid) busy[regf_waddr_i] <= 1'b0;
      if (sb_set_i && (sb_set_rd_i != '0)) busy[sb_set_rd_i] <= 1'b1;
    end
  end

  logic byp1, byp2;

  // Bypass is gated by reset so the read ports read zero while reset is held.
  assign byp1 = WR_BYPASS && rstn_i && wr_valid && (regf_waddr_i == rs1_addr_i);
  assign byp2 = WR_BYPASS && rstn_i && wr_valid && (regf_waddr_i == rs2_addr_i);

  always_comb begin
    rs1_data_o = '0;
    if (rs1_addr_i != '0) rs1_data_o = byp1 ? regf_wdata_i : regs[rs1_addr_i];
  end

  always_comb begin
    rs2_data_o = '0;
    if (rs2_addr_i != '0) rs2_data_o = byp2 ? regf_wdata_i : regs[rs2_addr_i];
  end

  // A completing write releases its consumer in the same cycle only when the
  // data is being forwarded; otherwise the consumer waits for the stored copy.
  assign rs1_busy_o = busy[rs1_addr_i] &&
                      !(WR_BYPASS && regf_write_i && (regf_waddr_i == rs1_addr_i));
  assign rs2_busy_o = busy[rs2_addr_i] &&
                      !(WR_BYPASS && regf_write_i && (regf_waddr_i == rs2_addr_i));
  assign stall_o    = rs1_busy_o || rs2_busy_o;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: bypassing and non-bypassing instances share
// stimulus and are compared every cycle against an architectural model.
module tb_reg_file_sb;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b1;
  logic        regf_write_i = 1'b0;
  logic [4:0]  regf_waddr_i = '0;
  logic [31:0] regf_wdata_i = '0;
  logic [4:0]  rs1_addr_i = '0;
  logic [4:0]  rs2_addr_i = '0;
  logic        sb_set_i = 1'b0;
  logic [4:0]  sb_set_rd_i = '0;
  logic        sb_flush_i = 1'b0;

  logic [31:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
  logic        b_rs1_busy, b_rs2_busy, b_stall, n_rs1_busy, n_rs2_busy, n_stall;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy = '0;

  reg_file_sb #(.XLEN(32), .NREGS(32), .WR_BYPASS(1'b1)) dut_byp (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .regf_write_i(regf_write_i), .regf_waddr_i(regf_waddr_i), .regf_wdata_i(regf_wdata_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(b_rs1_data), .rs2_data_o(b_rs2_data),
    .sb_set_i(sb_set_i), .sb_set_rd_i(sb_set_rd_i), .sb_flush_i(sb_flush_i),
    .rs1_busy_o(b_rs1_busy), .rs2_busy_o(b_rs2_busy), .stall_o(b_stall)
  );

  reg_file_sb #(.XLEN(32), .NREGS(32), .WR_BYPASS(1'b0)) dut_nob (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .regf_write_i(regf_write_i), .regf_waddr_i(regf_waddr_i), .regf_wdata_i(regf_wdata_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(n_rs1_data), .rs2_data_o(n_rs2_data),
    .sb_set_i(sb_set_i), .sb_set_rd_i(sb_set_rd_i), .sb_flush_i(sb_flush_i),
    .rs1_busy_o(n_rs1_busy), .rs2_busy_o(n_rs2_busy), .stall_o(n_stall)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Architectural view: x0 reads zero, a same-cycle write is visible only with
  // bypassing, and a pending register reads busy unless that write completes it.
  function automatic logic [31:0] expData(input bit byp, input logic [4:0] a);
    if (!rstn_i || a == 5'd0) return 32'h0;
    if (byp && regf_write_i && regf_waddr_i == a) return regf_wdata_i;
    return m_regs[a];
  endfunction

  function automatic logic expBusy(input bit byp, input logic [4:0] a);
    if (a == 5'd0 || !m_busy[a]) return 1'b0;
    return !(byp && regf_write_i && regf_waddr_i == a);
  endfunction

  always @(negedge rstn_i) begin
    for (int i = 0; i < 32; i++) m_regs[i] <= '0;
    m_busy <= '0;
  end

  always @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_busy <= '0;
    end else begin
      if (regf_write_i && regf_waddr_i != 5'd0) begin
        m_regs[regf_waddr_i] <= regf_wdata_i;
        m_busy[regf_waddr_i] <= 1'b0;
      end
      if (sb_set_i && sb_set_rd_i != 5'd0) m_busy[sb_set_rd_i] <= 1'b1;
      if (sb_flush_i) m_busy <= '0;
    end
  end

  always @(negedge clk_i) begin
    checkOutput("byp.rs1_data", b_rs1_data, expData(1'b1, rs1_addr_i));
    checkOutput("byp.rs2_data", b_rs2_data, expData(1'b1, rs2_addr_i));
    checkOutput("byp.rs1_busy", 32'(b_rs1_busy), 32'(expBusy(1'b1, rs1_addr_i)));
    checkOutput("byp.rs2_busy", 32'(b_rs2_busy), 32'(expBusy(1'b1, rs2_addr_i)));
    checkOutput("byp.stall", 32'(b_stall),
                32'(expBusy(1'b1, rs1_addr_i) | expBusy(1'b1, rs2_addr_i)));
    checkOutput("nob.rs1_data", n_rs1_data, expData(1'b0, rs1_addr_i));
    checkOutput("nob.rs2_data", n_rs2_data, expData(1'b0, rs2_addr_i));
    checkOutput("nob.rs1_busy", 32'(n_rs1_busy), 32'(expBusy(1'b0, rs1_addr_i)));
    checkOutput("nob.rs2_busy", 32'(n_rs2_busy), 32'(expBusy(1'b0, rs2_addr_i)));
    checkOutput("nob.stall", 32'(n_stall),
                32'(expBusy(1'b0, rs1_addr_i) | expBusy(1'b0, rs2_addr_i)));
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic set, input logic [4:0] srd, input logic flush);
    regf_write_i = wr;  regf_waddr_i = wa; regf_wdata_i = wd;
    rs1_addr_i   = r1;  rs2_addr_i   = r2;
    sb_set_i     = set; sb_set_rd_i  = srd; sb_flush_i = flush;
  endtask

  initial begin
    #1 rstn_i = 1'b0;
    repeat (2) step();
    rstn_i = 1'b0;
    step();
    rstn_i = 1'b1;

    // Reset state seen through both ports.
    applyStimulus(0, 0, 0, 5'd5, 5'd31, 0, 0, 0);
    #2;
    checkOutput("rst.rs1_data", b_rs1_data, 32'h0);
    checkOutput("rst.rs2_data", b_rs2_data, 32'h0);
    checkOutput("rst.stall", 32'(b_stall), 32'h0);

    applyStimulus(1, 5'd7, 32'hDEADBEEF, 5'd1, 5'd2, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 5'd7, 5'd7, 0, 0, 0);
    #2;
    checkOutput("wr.x7.byp", b_rs1_data, 32'hDEADBEEF);
    checkOutput("wr.x7.nob", n_rs2_data, 32'hDEADBEEF);

    // x0 ignores writes and scoreboard sets.
    applyStimulus(1, 5'd0, 32'h1234, 5'd0, 5'd0, 1, 5'd0, 0);
    step();
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 0, 0);
    #2;
    checkOutput("x0.data", b_rs1_data, 32'h0);
    checkOutput("x0.busy", 32'(b_rs1_busy), 32'h0);

    step();
    applyStimulus(1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, 0, 0, 0);
    #2;
    checkOutput("bypass.rs1", b_rs1_data, 32'hA5A5A5A5);
    checkOutput("bypass.rs2", b_rs2_data, 32'hA5A5A5A5);
    checkOutput("nobypass.old", n_rs1_data, 32'h0);
    step();
    applyStimulus(0, 0, 0, 5'd3, 5'd3, 0, 0, 0);
    #2;
    checkOutput("nobypass.new", n_rs2_data, 32'hA5A5A5A5);

    // Producer issues to x9, consumer stalls until write-back completes.
    step();
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 1, 5'd9, 0);
    step();
    applyStimulus(0, 0, 0, 5'd0, 5'd9, 0, 0, 0);
    #2;
    checkOutput("seqa.busy", 32'(b_rs2_busy), 32'h1);
    checkOutput("seqa.stall", 32'(n_stall), 32'h1);
    step();
    applyStimulus(1, 5'd9, 32'h55, 5'd0, 5'd9, 0, 0, 0);
    #2;
    checkOutput("seqa.unblock", 32'(b_rs2_busy), 32'h0);
    checkOutput("seqa.fwd", b_rs2_data, 32'h55);
    checkOutput("seqa.nob.busy", 32'(n_rs2_busy), 32'h1);
    step();
    applyStimulus(0, 0, 0, 5'd0, 5'd9, 0, 0, 0);
    #2;
    checkOutput("seqa.after", 32'(n_rs2_busy), 32'h0);

    // Set beats clear on the same register; flush beats set.
    step();
    applyStimulus(1, 5'd4, 32'h44, 5'd0, 5'd0, 1, 5'd4, 0);
    step();
    applyStimulus(0, 0, 0, 5'd4, 5'd0, 1, 5'd5, 0);
    #2;
    checkOutput("seqb.setwins", 32'(b_rs1_busy), 32'h1);
    step();
    applyStimulus(0, 0, 0, 5'd4, 5'd5, 1, 5'd4, 1);
    step();
    applyStimulus(0, 0, 0, 5'd4, 5'd5, 0, 0, 0);
    #2;
    checkOutput("seqb.flush", 32'(b_stall), 32'h0);

    // Reset asserted between edges clears outputs before the next edge.
    step();
    applyStimulus(1, 5'd10, 32'h77, 5'd0, 5'd0, 1, 5'd10, 0);
    step();
    applyStimulus(0, 0, 0, 5'd10, 5'd0, 0, 0, 0);
    #1;
    checkOutput("async.pre.data", b_rs1_data, 32'h77);
    checkOutput("async.pre.busy", 32'(b_rs1_busy), 32'h1);
    #1 rstn_i = 1'b0;
    #1;
    checkOutput("async.data", b_rs1_data, 32'h0);
    checkOutput("async.busy", 32'(b_rs1_busy), 32'h0);
    step();
    rstn_i = 1'b1;

    // Randomized traffic concentrated on a few registers to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      step();
      applyStimulus(($urandom_range(0, 1) == 1),
                    5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7)),
                    $urandom(),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 15) == 0));
    end
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
